booth_mult_unit: RTL and testbench

Multicycle signed 32×32 multiplier in the execute stage, beside the shift unit. It uses radix-2 Booth recoding over a 64-bit accumulator, with a multiplicand that is left-shifted one bit per iteration. It returns the low 32 bits of the product and an overflow flag. The execute stage stalls on `busy` and captures the result on the `data_resultRDY` pulse.

---
 rtl/booth_mult_unit.sv | 127 ++++++++++++
 tb/tb_booth_mult_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_unit.sv
// booth_mult_unit: multicycle signed 32x32 radix-2 Booth multiplier.
// Returns the low 32 bits of the product and a flag that is set when the
// full signed product does not fit in 32 bits. One iteration per clock.
module booth_mult_unit #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam int CW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   acc_q, acc_d;
  logic [63:0]   mcand_q, mcand_d;
  logic [31:0]   mplier_q, mplier_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   result_q, result_d;
  logic          exc_q, exc_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic [63:0]   acc_step;

  // Booth decode of the current multiplier bit pair: add, subtract or keep.
  always_comb begin
    acc_step = acc_q;
    case ({mplier_q[0], prev_q})
      2'b01:   acc_step = acc_q + mcand_q;
      2'b10:   acc_step = acc_q - mcand_q;
      default: acc_step = acc_q;
    endcase
  end

  // Next-state and datapath update; a start pulse overrides everything and
  // (re)loads the operands, which also covers abort in BUSY and restart in DONE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prev_d   = prev_q;
    count_d  = count_q;
    result_d = result_q;
    exc_d    = exc_q;

    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[62:0], 1'b0};
        prev_d   = mplier_q[0];
        mplier_d = {1'b0, mplier_q[31:1]};
        count_d  = count_q + {{(CW-1){1'b0}}, 1'b1};
        if (count_q == CW'(ITER - 1)) begin
          state_d  = S_DONE;
          result_d = acc_step[31:0];
          // Fits in 32 signed bits only if bits 63..31 are a pure sign extension.
          exc_d    = ~((&acc_step[63:31]) | ~(|acc_step[63:31]));
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (ctrl_MULT) begin
      state_d  = S_BUSY;
      acc_d    = 64'd0;
      mcand_d  = {{32{data_operandA[31]}}, data_operandA};
      mplier_d = data_operandB;
      prev_d   = 1'b0;
      count_d  = '0;
    end
  end

  // Status outputs are registered copies of the upcoming state.
  always_comb begin
    busy_d = (state_d == S_BUSY);
    rdy_d  = (state_d == S_DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      prev_q   <= 1'b0;
      count_q  <= '0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prev_q   <= prev_d;
      count_q  <= count_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_booth_mult_unit.sv
// Scoreboard bench for booth_mult_unit: expected products are queued on start
// and matched against each data_resultRDY pulse, including its arrival cycle.
module tb_booth_mult_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  booth_mult_unit #(.ITER(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        mon_en = 1'b0;
  logic [31:0] last_res = 32'd0;
  logic        last_exc = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: match each ready pulse against the scoreboard, check holding.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (data_resultRDY) begin
        chk("busy_at_rdy", {63'd0, busy}, 64'd0);
        if (sb.size() == 0) begin
          chk("spurious_rdy", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("txn: result=%h exc=%b expected %h/%b at cycle %0d",
                   data_result, data_exception, e.res, e.exc, cyc);
          chk("result", {32'd0, data_result}, {32'd0, e.res});
          chk("exception", {63'd0, data_exception}, {63'd0, e.exc});
          chk("latency", 64'(cyc), 64'(e.due));
          last_res = e.res;
          last_exc = e.exc;
        end
      end else begin
        chk("hold_result", {32'd0, data_result}, {32'd0, last_res});
        chk("hold_exception", {63'd0, data_exception}, {63'd0, last_exc});
        if (sb.size() != 0 && cyc > sb[0].due) begin
          chk("rdy_timeout", 64'(cyc), 64'(sb[0].due));
          void'(sb.pop_front());
        end
      end
    end
  end

  // Called #1 after a rising edge; the next edge is the start edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sbv, p;
    int n;
    n = cyc;
    // A still-pending operation whose pulse is not yet visible gets aborted.
    if (sb.size() != 0 && sb[sb.size()-1].due >= n + 1) void'(sb.pop_back());
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    p   = sa * sbv;
    e.res = p[31:0];
    e.exc = !((p[63:31] == 33'd0) || (p[63:31] == {33{1'b1}}));
    e.due = n + 33;
    sb.push_back(e);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_rdy();
    int i;
    for (i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (data_resultRDY) break;
    end
    if (i == 60) chk("wait_rdy_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_result", {32'd0, data_result}, 64'd0);
    chk("reset_exception", {63'd0, data_exception}, 64'd0);
    chk("reset_rdy", {63'd0, data_resultRDY}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(posedge clock); #1;

    // Directed products, including both overflow corners.
    start_op(32'd3, 32'd4);                 wait_idle();
    start_op(-32'sd7, 32'd6);               wait_idle();
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF);   wait_idle();
    start_op(32'h00010000, 32'h00010000);   wait_idle();
    start_op(32'h80000000, 32'hFFFFFFFF);   wait_idle();
    start_op(32'h80000000, 32'h80000000);   wait_idle();
    start_op(32'h7FFFFFFF, 32'h00000001);   wait_idle();

    // Random operand pairs, some restricted to small magnitudes.
    for (int k = 0; k < 6; k++) begin
      if (k < 3) start_op($urandom, $urandom);
      else start_op($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
      wait_idle();
    end

    // Abort: second start while busy replaces the first operation.
    start_op(32'd5, 32'd5);
    repeat (8) begin @(posedge clock); #1; end
    start_op(32'd2, 32'd9);
    wait_idle();

    // Asynchronous reset in the middle of an operation.
    start_op(32'd7, 32'd11);
    repeat (13) begin @(posedge clock); #1; end
    #2 reset = 1'b1;
    #1;
    chk("midreset_result", {32'd0, data_result}, 64'd0);
    chk("midreset_exception", {63'd0, data_exception}, 64'd0);
    chk("midreset_rdy", {63'd0, data_resultRDY}, 64'd0);
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    sb.delete();
    last_res = 32'd0;
    last_exc = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    repeat (40) begin @(posedge clock); #1; end
    start_op(32'd3, 32'd4);
    wait_idle();

    // Back-to-back: restart during the DONE cycle.
    start_op(32'd3, 32'd4);
    wait_rdy();
    start_op(-32'sd2, 32'd3);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", sb.size());
    $fatal(1, "watchdog");
  end

endmodule
